// File: rtl/mem_read_port.sv
// Multi-cycle data-memory read controller: req/ack handshake with timeout,
// little-endian lane extraction and sign/zero extension into the memory data register.
module mem_read_port #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] odat,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  a_lo;
    logic [1:0]  sz;
    logic        sx;
    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext;

    // size 3 decodes as word, so size[1] covers both word encodings
    assign misaligned = ((size == 2'd1) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));

    always_comb begin
        lane_b = mem_rdata[7:0];
        case (a_lo)
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            2'd3:    lane_b = mem_rdata[31:24];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = a_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (sz)
            2'd0:    ext = {{24{sx & lane_b[7]}}, lane_b};
            2'd1:    ext = {{16{sx & lane_h[15]}}, lane_h};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            a_lo     <= 2'd0;
            sz       <= 2'd0;
            sx       <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 32'd0;
            odat     <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemRead) begin
                        a_lo     <= addr[1:0];
                        sz       <= size;
                        sx       <= sign_ext;
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (misaligned) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            cnt     <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    // ack is checked first so it wins over a simultaneous timeout
                    if (mem_ack) begin
                        odat    <= ext;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt + 8'd1 == TO) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        cnt     <= 8'd0;
                        state   <= ERR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_port.sv
// Bench for mem_read_port: directed and random reads checked cycle by cycle
// against an arithmetic model of extraction and handshake timing.
module tb_mem_read_port;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        MemRead = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [1:0]  size = 2'd0;
    logic        sign_ext = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] odat;
    logic        done;
    logic        err;
    logic        busy;

    int          cmp = 0;
    int          bad = 0;
    logic [31:0] exp_odat = 32'd0;

    mem_read_port #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .addr(addr), .size(size),
        .sign_ext(sign_ext), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .odat(odat), .done(done),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [31:0] a,
                                            input logic [1:0] sz, input logic sx);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'h0000_00FF;
            if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
            if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One read issued in the current cycle (cycle 0); ack driven in cycle ack_at
    // (0 = never). With noise, MemRead toggles while busy and ack toggles after REQ.
    task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                           input logic [31:0] rd, input int ack_at, input bit noise);
        bit          mis, acked, e_req, e_done, e_err;
        int          req_last, last_busy;
        logic [31:0] model, prev, e_addr;
        mis       = (sz == 2'd1 && (a % 2) == 1) || (sz >= 2'd2 && (a % 4) != 0);
        acked     = !mis && ack_at >= 1 && ack_at <= TO;
        req_last  = mis ? 0 : (acked ? ack_at : TO);
        last_busy = mis ? 1 : req_last + 1;
        model     = ref_ext(rd, a, sz, sx);
        prev      = exp_odat;
        e_addr    = a - (a % 4);
        MemRead = 1'b1; addr = a; size = sz; sign_ext = sx;
        @(posedge clk); #1;
        MemRead = 1'b0; addr = $urandom; size = 2'($urandom); sign_ext = 1'($urandom);
        for (int c = 1; c <= last_busy; c++) begin
            MemRead   = noise ? 1'($urandom) : 1'b0;
            mem_ack   = (c == ack_at) || (noise && c > req_last && 1'($urandom));
            mem_rdata = (c == ack_at) ? rd : $urandom;
            e_req  = c <= req_last;
            e_done = acked && c == ack_at + 1;
            e_err  = mis ? (c == 1) : (!acked && c == TO + 1);
            cmp += 5;
            if (mem_req !== e_req) begin bad++; $display("FAIL mem_req c=%0d got %b exp %b", c, mem_req, e_req); end
            if (done !== e_done) begin bad++; $display("FAIL done c=%0d got %b exp %b", c, done, e_done); end
            if (err !== e_err) begin bad++; $display("FAIL err c=%0d got %b exp %b", c, err, e_err); end
            if (busy !== 1'b1) begin bad++; $display("FAIL busy c=%0d got %b exp 1", c, busy); end
            if (odat !== (e_done ? model : prev)) begin
                bad++; $display("FAIL odat c=%0d got %h exp %h", c, odat, e_done ? model : prev);
            end
            if (e_req) begin
                cmp++;
                if (mem_addr !== e_addr) begin bad++; $display("FAIL mem_addr c=%0d got %h exp %h", c, mem_addr, e_addr); end
            end
            @(posedge clk); #1;
        end
        MemRead = 1'b0; mem_ack = 1'b0;
        if (acked) exp_odat = model;
        cmp += 4;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_end got %b exp 0", busy); end
        if (mem_req !== 1'b0) begin bad++; $display("FAIL mem_req_end got %b exp 0", mem_req); end
        if ({done, err} !== 2'b00) begin bad++; $display("FAIL pulse_end got %b exp 00", {done, err}); end
        if (odat !== exp_odat) begin bad++; $display("FAIL odat_end got %h exp %h", odat, exp_odat); end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        cmp += 2;
        if ({mem_req, done, err, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got %b exp 0000", {mem_req, done, err, busy});
        end
        if ({odat, mem_addr} !== 64'd0) begin
            bad++; $display("FAIL reset_data got %h/%h exp 0/0", odat, mem_addr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_odat = 32'd0;
    endtask

    task automatic test_word();
        do_read(32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 3, 1'b0);
        cmp++;
        if (odat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word got %h exp deadbeef", odat); end
    endtask

    task automatic test_byte();
        do_read(32'h0000_0013, 2'd0, 1'b1, 32'h80AA_5500, 2, 1'b0);
        cmp++;
        if (odat !== 32'hFFFF_FF80) begin bad++; $display("FAIL byte_sx got %h exp ffffff80", odat); end
        do_read(32'h0000_0013, 2'd0, 1'b0, 32'h80AA_5500, 1, 1'b0);
        cmp++;
        if (odat !== 32'h0000_0080) begin bad++; $display("FAIL byte_zx got %h exp 00000080", odat); end
        do_read(32'h0000_0011, 2'd0, 1'b1, 32'h80AA_5500, 4, 1'b0);
        cmp++;
        if (odat !== 32'h0000_0055) begin bad++; $display("FAIL byte_lane1 got %h exp 00000055", odat); end
    endtask

    task automatic test_half();
        do_read(32'h0000_0022, 2'd1, 1'b1, 32'h8001_1234, 2, 1'b0);
        cmp++;
        if (odat !== 32'hFFFF_8001) begin bad++; $display("FAIL half_sx got %h exp ffff8001", odat); end
        do_read(32'h0000_0021, 2'd1, 1'b1, 32'h8001_1234, 1, 1'b0);
        cmp++;
        if (odat !== 32'hFFFF_8001) begin bad++; $display("FAIL half_mis got %h exp ffff8001", odat); end
        do_read(32'h0000_0042, 2'd3, 1'b0, 32'h1111_2222, 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_read(32'h0000_0100, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
        do_read(32'h0000_0104, 2'd2, 1'b0, 32'hCAFE_F00D, TO + 1, 1'b0);
        do_read(32'h0000_0108, 2'd2, 1'b0, 32'h0BAD_CAFE, TO, 1'b0);
        cmp++;
        if (odat !== 32'h0BAD_CAFE) begin bad++; $display("FAIL ack_at_timeout got %h exp 0badcafe", odat); end
    endtask

    task automatic test_back_to_back();
        do_read(32'h0000_0200, 2'd2, 1'b0, 32'h1234_5678, 1, 1'b0);
        do_read(32'h0000_0206, 2'd1, 1'b0, 32'hA5A5_0000, 1, 1'b0);
        cmp++;
        if (odat !== 32'h0000_A5A5) begin bad++; $display("FAIL b2b got %h exp 0000a5a5", odat); end
    endtask

    task automatic test_ignored();
        do_read(32'h0000_0300, 2'd2, 1'b0, 32'h7777_8888, 5, 1'b1);
        do_read(32'h0000_0302, 2'd1, 1'b0, 32'h7777_8888, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            @(posedge clk); #1;
            cmp++;
            if ({mem_req, done, err, busy} !== 4'b0000 || odat !== exp_odat) begin
                bad++; $display("FAIL idle_ack got %b/%h exp 0000/%h", {mem_req, done, err, busy}, odat, exp_odat);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        MemRead = 1'b1; addr = 32'h0000_0400; size = 2'd2;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        cmp++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL pre_rst_req got %b exp 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        cmp++;
        if ({mem_req, busy} !== 2'b00 || odat !== 32'd0) begin
            bad++; $display("FAIL async_rst got %b/%h exp 00/0", {mem_req, busy}, odat);
        end
        @(negedge clk) rst_n = 1'b1;
        exp_odat = 32'd0;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        cmp++;
        if ({done, busy} !== 2'b00 || odat !== 32'd0) begin
            bad++; $display("FAIL late_ack got %b/%h exp 00/0", {done, busy}, odat);
        end
        do_read(32'h0000_0404, 2'd0, 1'b1, 32'h0000_FE00, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        int          ack_at;
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 2);
            do_read(a, sz, 1'($urandom), $urandom, ack_at, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_timeout();
        test_back_to_back();
        test_ignored();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_port.md
# mem_read_port

Multi-cycle memory read controller for the multi-clock CPU datapath. It accepts a one-cycle read command from the control unit and runs a req/ack handshake with data memory. It extracts and extends the addressed byte, halfword or word, then loads the result into the memory data register output. It is the read-side counterpart to the write-enabled datapath registers, and its `odat` feeds the write-back mux.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` stays high without `mem_ack` before the transaction is aborted; legal range 1..255.
- `clk`  in  1  single system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  one-cycle command strobe; sampled only in IDLE.
- `addr`  in  32  byte address, sampled with `MemRead`.
- `size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `sign_ext`  in  1  1 = sign-extend byte/halfword, 0 = zero-extend.
- `mem_req`  out  1  read request to memory.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`, held stable while `mem_req` = 1.
- `mem_rdata`  in  32  memory read data, valid in the cycle `mem_ack` = 1.
- `mem_ack`  in  1  memory completion, one cycle.
- `odat`  out  32  memory data register; holds its value until the next successful read.
- `done`  out  1  one-cycle pulse when `odat` is updated.
- `err`  out  1  one-cycle pulse on a misaligned access or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE, `MemRead` = 1:
  - Latch `addr`, `size` and `sign_ext`.
  - Misaligned access goes to ERR. Misaligned means halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Otherwise go to REQ and clear the timeout counter.
- REQ:
  - `mem_req` = 1.
  - `mem_ack` = 1: capture the extracted data into `odat`, go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to ERR and drop `mem_req`.
- DONE: `done` = 1, go to IDLE.
- ERR: `err` = 1, `odat` unchanged, go to IDLE.
- Extraction uses little-endian lanes:
  - Byte = `mem_rdata[8*a[1:0] +: 8]`.
  - Half = `mem_rdata[16*a[1] +: 16]`.
  - Word = all 32 bits.
  - `a` is the latched address.
- Extension: if `sign_ext` = 1, replicate bit 7 (byte) or bit 15 (half) upward; otherwise fill with zeros.
- `MemRead` outside IDLE is ignored. It is not queued.
- `mem_ack` outside REQ is ignored.
- `mem_rdata` is ignored unless `mem_ack` = 1 in REQ.

## Timing
- Reset (async, `rst_n` = 0):
  - State IDLE, counter 0.
  - `odat` = 0, `mem_req` = 0, `done` = 0, `err` = 0, `busy` = 0.
  - `mem_addr` = 0.
- Reset mid-transaction: `mem_req` drops immediately (asynchronously); any ack arriving afterwards is ignored.
- `MemRead` in cycle 0 gives `mem_req` = 1 from cycle 1.
- `mem_ack` sampled in cycle k gives:
  - `odat` valid and `done` = 1 in cycle k+1;
  - `mem_req` = 0 in cycle k+1;
  - `busy` = 0 in cycle k+2.
- Zero-wait memory (ack in cycle 1): `done` in cycle 2; the next `MemRead` is accepted in cycle 3.
- Timeout: with no ack, `mem_req` is high for exactly `TIMEOUT` cycles (cycles 1..`TIMEOUT`). `err` = 1 in cycle `TIMEOUT`+1.
- An ack in the same cycle the counter reaches `TIMEOUT` wins: the read completes, no error.
- Misaligned access: `err` in cycle 1, `mem_req` never asserted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then word read at 0x0000_0010 with `mem_rdata` = 0xDEAD_BEEF acked in cycle 3 -> `mem_addr` = 0x10, `odat` = 0xDEAD_BEEF and `done` in cycle 4, `busy` low in cycle 5.
- Byte reads at 0x13, rdata 0x80AA_5500:
  - `sign_ext` = 1 -> `odat` = 0xFFFF_FF80;
  - `sign_ext` = 0 -> `odat` = 0x0000_0080;
  - byte read at 0x11 -> 0x0000_0055.
- Halfword read at 0x22, `sign_ext` = 1, rdata 0x8001_1234 -> `odat` = 0xFFFF_8001. Halfword at 0x21 -> `err` in cycle 1, no `mem_req`, `odat` unchanged.
- `TIMEOUT` = 15, no ack -> `mem_req` high for exactly 15 cycles, `err` pulse in cycle 16, `odat` unchanged. Repeat with ack in cycle 15 -> `done`, no `err`.
- `MemRead` pulses during REQ, plus a spurious `mem_ack` while in IDLE -> no extra transactions, `odat` and `done` unaffected.
- `rst_n` low while in REQ -> `mem_req` and `busy` drop without waiting for a clock edge, `odat` = 0. A subsequent ack is ignored, and a new read completes normally.
